// File: rtl/buttons_reader.sv
// Debounced reader for N raw push-buttons/switches.
// 2-flop synchronizer per bit, then a per-bit stability counter.
module buttons_reader #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw_in,
    output logic [N-1:0] sw_state,
    output logic [N-1:0] press,
    // "release" is a reserved word, so the release pulse is named released
    output logic [N-1:0] released,
    output logic         any_change
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  x;
    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [CW-1:0] cnt [N];

    assign x = ACTIVE_LOW ? ~sw_in : sw_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            sw_state <= '0;
            press    <= '0;
            released <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= x;
            s2 <= s1;
            for (int i = 0; i < N; i++) begin
                press[i]    <= 1'b0;
                released[i] <= 1'b0;
                if (s2[i] == sw_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    // window complete: accept the new level and pulse once
                    sw_state[i] <= s2[i];
                    cnt[i]      <= '0;
                    press[i]    <= s2[i];
                    released[i] <= ~s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign any_change = |(press | released);

endmodule
